// File: rtl/serial_bit_feeder.sv
// serial_bit_feeder: parallel-in, serial-out feeder for a serial sequence detector.
// Ports: clk/reset (sync, active-high); data_in/load_valid/load_ready word handshake;
//        dout/dout_valid registered serial stream; busy status; words_sent wrapping count.
// Latency: first bit is driven one edge after the accept edge. Back-to-back words stream
//          with no gap through a one-word holding register. load_ready is low while it is full.
module serial_bit_feeder #(
  parameter int WIDTH      = 8,
  parameter bit MSB_FIRST  = 1'b1,
  parameter bit IDLE_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             dout,
  output logic             dout_valid,
  output logic             busy,
  output logic [7:0]       words_sent
);

  localparam int           CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state;
  logic [WIDTH-1:0] hold;
  logic             hold_full;
  logic [WIDTH-1:0] shreg;
  logic [CW-1:0]    bit_cnt;

  logic             last_bit;
  logic             transfer;
  logic             accept;
  logic [WIDTH-1:0] shreg_nxt;

  // Bit that leaves first from a word aligned the way shreg holds it.
  function automatic logic out_bit(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  assign load_ready = !hold_full && !reset;
  assign accept     = load_valid && load_ready;
  assign last_bit   = (state == SHIFT) && (bit_cnt == LAST);
  // The held word moves into the shifter either from idle or exactly as the
  // current word's last bit is being driven, which gives the zero-gap stream.
  assign transfer   = hold_full && ((state == IDLE) || last_bit);
  assign busy       = (state == SHIFT) || hold_full;

  // Move the next bit into the output end of shreg.
  always_comb begin
    shreg_nxt = shreg;
    if (MSB_FIRST) begin
      shreg_nxt = {shreg[WIDTH-2:0], 1'b0};
    end else begin
      shreg_nxt = {1'b0, shreg[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      hold       <= '0;
      hold_full  <= 1'b0;
      shreg      <= '0;
      bit_cnt    <= '0;
      dout       <= IDLE_LEVEL;
      dout_valid <= 1'b0;
      words_sent <= 8'd0;
    end else begin
      if (accept) begin
        hold      <= data_in;
        hold_full <= 1'b1;
      end else if (transfer) begin
        hold_full <= 1'b0;
      end

      if (last_bit) begin
        words_sent <= words_sent + 8'd1;
      end

      if (transfer) begin
        state      <= SHIFT;
        shreg      <= hold;
        bit_cnt    <= '0;
        dout       <= out_bit(hold);
        dout_valid <= 1'b1;
      end else if (state == SHIFT) begin
        if (last_bit) begin
          state      <= IDLE;
          bit_cnt    <= '0;
          dout       <= IDLE_LEVEL;
          dout_valid <= 1'b0;
        end else begin
          bit_cnt    <= bit_cnt + 1'b1;
          shreg      <= shreg_nxt;
          dout       <= out_bit(shreg_nxt);
          dout_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_serial_bit_feeder.sv
// tb_serial_bit_feeder: drives an MSB-first and an LSB-first feeder with identical stimulus.
// Expected outputs come from a word-schedule model: each accepted word gets a start edge,
// and its bits, ready, busy and the sent count follow from that schedule arithmetic.
module tb_serial_bit_feeder;

  localparam int W = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] data_in;
  logic       load_valid;
  logic       ready_m, dout_m, valid_m, busy_m;
  logic       ready_l, dout_l, valid_l, busy_l;
  logic [7:0] ws_m, ws_l;

  always #5 clk = ~clk;

  serial_bit_feeder #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) dut_m (
    .clk(clk), .reset(reset), .data_in(data_in), .load_valid(load_valid),
    .load_ready(ready_m), .dout(dout_m), .dout_valid(valid_m), .busy(busy_m),
    .words_sent(ws_m));

  serial_bit_feeder #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) dut_l (
    .clk(clk), .reset(reset), .data_in(data_in), .load_valid(load_valid),
    .load_ready(ready_l), .dout(dout_l), .dout_valid(valid_l), .busy(busy_l),
    .words_sent(ws_l));

  int checks = 0;
  int errors = 0;

  typedef struct { logic [7:0] w; int start; } word_t;
  word_t q[$];
  int    edge_n = 0;
  int    sent = 0;     // unwrapped count since last reset

  bit    cap_m[$];     // valid bits seen on the MSB-first feeder
  bit    cap_l[$];
  int    first_v, last_v;

  typedef struct {
    logic       lv;
    logic [7:0] d;
    logic       dout, vld, rdy, busy;
    logic [7:0] ws;
  } vec_t;
  vec_t tbl[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_n);
    end
  endtask

  function automatic bit pending(input int e);
    foreach (q[i]) if (q[i].start > e) return 1'b1;
    return 1'b0;
  endfunction

  task automatic step(input logic r, input logic lv, input logic [7:0] d);
    logic rdy_before;
    logic exp_m, exp_l, exp_v, exp_rdy, exp_busy;
    int   i;
    reset = r; load_valid = lv; data_in = d;
    rdy_before = !r && !pending(edge_n);
    @(posedge clk);
    edge_n++;
    if (r) begin
      q.delete();
      sent = 0;
    end else begin
      if (q.size() > 0 && q[0].start + W - 1 == edge_n - 1) begin
        void'(q.pop_front());
        sent++;
      end
      if (lv && rdy_before) begin
        word_t nw;
        nw.w = d;
        nw.start = (q.size() == 0) ? edge_n + 1 : q[$].start + W;
        q.push_back(nw);
      end
    end
    @(negedge clk);
    exp_m = 1'b0; exp_l = 1'b0; exp_v = 1'b0;
    if (q.size() > 0 && q[0].start <= edge_n) begin
      logic [7:0] w;
      w = q[0].w;
      i = edge_n - q[0].start;
      exp_m = w[W-1-i];
      exp_l = w[i];
      exp_v = 1'b1;
    end
    exp_rdy  = !r && !pending(edge_n);
    exp_busy = (q.size() > 0);
    chk("m_dout", dout_m, exp_m);
    chk("m_valid", valid_m, exp_v);
    chk("m_ready", ready_m, exp_rdy);
    chk("m_busy", busy_m, exp_busy);
    chk("m_words", ws_m, sent % 256);
    chk("l_dout", dout_l, exp_l);
    chk("l_valid", valid_l, exp_v);
    chk("l_ready", ready_l, exp_rdy);
    chk("l_busy", busy_l, exp_busy);
    chk("l_words", ws_l, sent % 256);
    if (valid_m === 1'b1) begin
      if (cap_m.size() == 0) first_v = edge_n;
      last_v = edge_n;
      cap_m.push_back(dout_m);
    end
    if (valid_l === 1'b1) cap_l.push_back(dout_l);
  endtask

  task automatic clear_cap();
    cap_m.delete(); cap_l.delete();
    first_v = -1; last_v = -1;
  endtask

  initial begin
    int det;
    int prev;
    logic [15:0] stream;
    logic [7:0]  got;

    reset = 1'b1; load_valid = 1'b0; data_in = 8'h00;
    @(negedge clk);

    // Reset with a valid word offered: nothing may be taken.
    step(1'b1, 1'b1, 8'hFF);
    step(1'b1, 1'b1, 8'hFF);
    chk("rst_dout", dout_m, 1'b0);
    chk("rst_valid", valid_m, 1'b0);
    chk("rst_busy", busy_m, 1'b0);
    chk("rst_words", ws_m, 8'd0);
    chk("rst_ready", ready_m, 1'b0);
    step(1'b0, 1'b0, 8'h00);
    chk("rst_no_accept_busy", busy_m, 1'b0);
    chk("rst_no_accept_valid", valid_m, 1'b0);

    // Single word 0x99, table-driven.
    tbl[0] = '{1'b1, 8'h99, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0};
    tbl[1] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 8'd0};
    tbl[2] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 8'd0};
    tbl[3] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 8'd0};
    tbl[4] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 8'd0};
    tbl[5] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 8'd0};
    tbl[6] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 8'd0};
    tbl[7] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 8'd0};
    tbl[8] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 8'd0};
    tbl[9] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'd1};
    clear_cap();
    for (int k = 0; k < 10; k++) begin
      step(1'b0, tbl[k].lv, tbl[k].d);
      chk($sformatf("tbl%0d_dout", k), dout_m, tbl[k].dout);
      chk($sformatf("tbl%0d_valid", k), valid_m, tbl[k].vld);
      chk($sformatf("tbl%0d_ready", k), ready_m, tbl[k].rdy);
      chk($sformatf("tbl%0d_busy", k), busy_m, tbl[k].busy);
      chk($sformatf("tbl%0d_words", k), ws_m, tbl[k].ws);
    end
    chk("single_nbits", cap_m.size(), 8);
    det = 0;
    for (int k = 0; k + 3 < cap_m.size(); k++)
      if (cap_m[k] && !cap_m[k+1] && !cap_m[k+2] && cap_m[k+3]) det++;
    chk("single_det1001", det, 2);

    // Back-to-back 0x99 then 0x4B with load_valid held until the second is taken.
    step(1'b1, 1'b0, 8'h00);
    clear_cap();
    step(1'b0, 1'b1, 8'h99);
    step(1'b0, 1'b1, 8'h4B);
    chk("b2b_ready_low_hold", ready_m, 1'b1);
    step(1'b0, 1'b1, 8'h4B);
    chk("b2b_ready_low", ready_m, 1'b0);
    for (int k = 0; k < 18; k++) step(1'b0, 1'b0, 8'h00);
    chk("b2b_nbits", cap_m.size(), 16);
    chk("b2b_contig", last_v - first_v + 1, 16);
    stream = '0;
    foreach (cap_m[k]) stream = {stream[14:0], cap_m[k]};
    chk("b2b_stream", stream, 16'h994B);
    chk("b2b_words", ws_m, 8'd2);

    // LSB-first feeder with 0x01.
    step(1'b1, 1'b0, 8'h00);
    clear_cap();
    step(1'b0, 1'b1, 8'h01);
    for (int k = 0; k < 10; k++) step(1'b0, 1'b0, 8'h00);
    got = '0;
    for (int k = 0; k < 8 && k < cap_l.size(); k++) got[7-k] = cap_l[k];
    chk("lsb_nbits", cap_l.size(), 8);
    chk("lsb_seq_first_is_bit0", got, 8'b1000_0000);
    chk("lsb_words", ws_l, 8'd1);

    // Reset while bit 3 of 0x99 is on dout with 0x4B held.
    step(1'b1, 1'b0, 8'h00);
    step(1'b0, 1'b1, 8'h99);          // accept at edge k
    step(1'b0, 1'b1, 8'h4B);          // k+1: bit 0
    step(1'b0, 1'b1, 8'h4B);          // k+2: bit 1, 0x4B accepted
    step(1'b0, 1'b0, 8'h00);          // k+3: bit 2
    step(1'b0, 1'b0, 8'h00);          // k+4: bit 3
    chk("mid_bit3", dout_m, 1'b1);
    chk("mid_hold_busy", busy_m, 1'b1);
    step(1'b1, 1'b0, 8'h00);
    chk("mid_dout", dout_m, 1'b0);
    chk("mid_valid", valid_m, 1'b0);
    chk("mid_busy", busy_m, 1'b0);
    chk("mid_words", ws_m, 8'd0);
    clear_cap();
    for (int k = 0; k < 20; k++) step(1'b0, 1'b0, 8'h00);
    chk("mid_no_4B", cap_m.size(), 0);

    // Stream 256 words to see the counter wrap.
    step(1'b1, 1'b0, 8'h00);
    prev = 0;
    for (int k = 0; k < 256 * W + 20 && sent < 256; k++) begin
      step(1'b0, 1'b1, 8'($urandom));
      if (sent != prev) begin
        if (sent == 255) chk("wrap_255", ws_m, 8'd255);
        if (sent == 256) chk("wrap_0", ws_m, 8'd0);
        prev = sent;
      end
    end
    chk("wrap_reached", sent, 256);

    // Random traffic with occasional resets.
    for (int k = 0; k < 3000; k++) begin
      step(($urandom_range(0, 39) == 0), ($urandom_range(0, 1) == 1), 8'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/serial_bit_feeder.md
# serial_bit_feeder

Parallel-in, serial-out feeder that sits directly upstream of the overlapping Moore sequence detector. It accepts WIDTH-bit words over a valid/ready handshake and shifts them out one bit per clock on `dout`, which drives the detector's `din`. A one-word holding register lets back-to-back words stream with no idle bit between them, so patterns that span a word boundary are still detected. A wrapping word counter is provided for bench and debug visibility.

## Interface
- `WIDTH`, default 8: word width in bits; legal range 2..32.
- `MSB_FIRST`, default 1: 1 shifts bit WIDTH-1 first; 0 shifts bit 0 first.
- `IDLE_LEVEL`, default 0: value driven on `dout` whenever no bit is valid.

- `clk`  input  1  clock; all state updates on the rising edge.
- `reset`  input  1  synchronous, active-high reset.
- `data_in`  input  WIDTH  word to serialize.
- `load_valid`  input  1  `data_in` is valid.
- `load_ready`  output  1  feeder can accept a word this cycle.
- `dout`  output  1  serial bit stream to the detector's `din`.
- `dout_valid`  output  1  `dout` carries a data bit this cycle.
- `busy`  output  1  shifter active or holding register full.
- `words_sent`  output  8  count of fully shifted words, wraps at 256.

## Operation
- State: holding register `hold` with flag `hold_full`; shift register `shreg`; bit index `bit_cnt` (0..WIDTH-1); FSM {IDLE, SHIFT}.
- Accept: at an edge where `load_valid && load_ready`, write `data_in` into `hold` and set `hold_full`.
- `load_ready = !hold_full && !reset`. This is combinational from state and `reset` only; it has no path from `load_valid`.
- Transfer: at an edge where `hold_full` is set and (FSM=IDLE, or FSM=SHIFT with `bit_cnt=WIDTH-1`):
  - load `shreg` from `hold`, clear `hold_full`;
  - set `bit_cnt=0` and FSM=SHIFT.
- Accept and transfer never occur on the same edge: accept needs `hold_full=0`, transfer needs `hold_full=1`.
- SHIFT, `bit_cnt<WIDTH-1`: each edge advances `bit_cnt` and shifts `shreg` toward the output end.
- SHIFT, `bit_cnt=WIDTH-1`, no transfer pending: next edge goes to IDLE.
- `dout` in SHIFT: MSB_FIRST=1 gives the bit index WIDTH-1-`bit_cnt` of the loaded word; MSB_FIRST=0 gives bit index `bit_cnt`.
- `dout` in IDLE: IDLE_LEVEL.
- `dout_valid` is 1 exactly when FSM=SHIFT. `dout` and `dout_valid` are registered outputs.
- `busy` is high when FSM=SHIFT or `hold_full`.
- `words_sent` increments by 1 on every edge that ends a cycle in which `bit_cnt=WIDTH-1` was driven, whether or not the next word follows. It wraps 255 -> 0 with no saturation.
- Reset, including mid-word:
  - FSM=IDLE, `hold_full=0`, `bit_cnt=0`, `shreg=0`;
  - `dout=IDLE_LEVEL`, `dout_valid=0`, `busy=0`, `words_sent=0`;
  - the partial word and the held word are discarded;
  - `load_ready` is 0 while `reset` is high, so no word is accepted in a reset cycle.

## Timing
- Word accepted at edge k: first bit on `dout` with `dout_valid=1` after edge k+1.
- Bit i is driven after edge k+1+i; the last bit is driven after edge k+WIDTH.
- Edge k+WIDTH+1: `words_sent` increments. Then either the next word's first bit appears (holding register was full, giving zero gap) or `dout` returns to IDLE_LEVEL with `dout_valid=0`.
- `load_ready` drops after the accept edge k and rises again after transfer edge k+1.
  - Sustained `load_valid` therefore gives a new accept every WIDTH cycles during streaming.
  - The second accept lands at edge k+2.
- Minimum latency from `load_valid` (with `load_ready` high) to first valid bit: 1 edge after accept.

## Test plan
- Reset behaviour: hold `reset=1` for 2 cycles with `load_valid=1`, `data_in=8'hFF`. Required:
  - `dout=0`, `dout_valid=0`, `busy=0`, `words_sent=0`, `load_ready=0`;
  - no word is accepted.
- Single word: MSB_FIRST=1, accept `8'h99` at edge k. Required:
  - `dout` = 1,0,0,1,1,0,0,1 after edges k+1..k+8, with `dout_valid=1` exactly 8 cycles;
  - `dout=0` and `words_sent=1` after edge k+9;
  - a downstream 1001 detector pulses twice.
- Back-to-back: `8'h99` then `8'h4B` with `load_valid` held high. Required:
  - 16 contiguous valid bits 10011001 01001011 with no gap;
  - `load_ready` is low while `hold_full` is set;
  - `words_sent=2` at the end.
- LSB-first: MSB_FIRST=0, word `8'h01`. Required:
  - `dout` = 1,0,0,0,0,0,0,0;
  - `words_sent=1` at the end.
- Reset mid-word: assert `reset` for 1 cycle while bit 3 of `8'h99` is on `dout`, with `8'h4B` held. Required:
  - after that edge, `dout=0`, `dout_valid=0`, `busy=0`, `words_sent=0`;
  - `8'h4B` never appears on `dout`.
- Counter wrap: stream 256 words. Required:
  - `words_sent` reads 255 after the 255th word and 0 after the 256th.
